// File: rtl/inc_cmd_sequencer.sv
`timescale 1ns/1ps
// Command sequencer for a downstream 4-bit counter stage.
// Commands are {op, arg}. op 0 is LOAD and op 1 is INC.
// Commands are queued in a small FIFO and executed strictly in order.
// LOAD issues one ld strobe carrying the value.
// INC issues arg en strobes; en is held off while stall is high.
// shadow tracks what the counter stage should hold after the strobes issued so far.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting; pops the FIFO head whenever the FIFO is non-empty
//   LOAD  | one cycle: ld=1, ui=arg, done=1
//   INC   | en once per unstalled cycle until remaining hits 0, then done
module inc_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    input  logic [3:0] cmd_arg,
    output logic       cmd_ready,
    input  logic       stall,
    output logic       ld,
    output logic [3:0] ui,
    output logic       en,
    output logic [3:0] shadow,
    output logic       done,
    output logic       busy,
    output logic [7:0] issued
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_INC  = 2'd2;

    // Command FIFO storage and bookkeeping
    logic [4:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0] state;
    logic [3:0] cur_arg;
    logic [3:0] remaining;

    logic       push;
    logic       pop;
    logic       head_op;
    logic [3:0] head_arg;

    // cmd_ready only looks at registered occupancy, so a full FIFO refuses a
    // push even in a cycle where the FSM is popping.
    assign cmd_ready = (count != CNT_FULL);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign head_op   = fifo_mem[rd_ptr][4];
    assign head_arg  = fifo_mem[rd_ptr][3:0];

    // FIFO storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_arg};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sequencing FSM: pop in IDLE, execute LOAD/INC, and track the expected counter value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cur_arg   <= 4'h0;
            remaining <= 4'h0;
            shadow    <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head_op) begin
                            remaining <= head_arg;
                            state     <= ST_INC;
                        end else begin
                            cur_arg <= head_arg;
                            state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    shadow <= cur_arg;
                    state  <= ST_IDLE;
                end
                ST_INC: begin
                    if (remaining == 4'h0) begin
                        state <= ST_IDLE;
                    end else if (!stall) begin
                        remaining <= remaining - 4'd1;
                        shadow    <= shadow + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completed-command counter, saturating so it never wraps back to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued <= 8'h00;
        end else if (done && (issued != 8'hFF)) begin
            issued <= issued + 8'd1;
        end
    end

    // Strobes decode from the registered state; en also depends on the live stall input
    always_comb begin
        ld   = (state == ST_LOAD);
        ui   = ld ? cur_arg : 4'h0;
        en   = (state == ST_INC) && !stall && (remaining != 4'h0);
        done = ld || ((state == ST_INC) && (remaining == 4'h0));
        busy = (state != ST_IDLE) || (count != '0);
    end

endmodule

// File: tb/tb_inc_cmd_sequencer.sv
`timescale 1ns/1ps
// Bench for inc_cmd_sequencer.
// A transaction-level model tracks accepted commands in order.
// It checks each ld/en/done strobe against the command at the head of the queue.
module tb_inc_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_op = 1'b0;
    logic [3:0] cmd_arg = 4'h0;
    logic       stall = 1'b0;
    logic       cmd_ready;
    logic       ld;
    logic [3:0] ui;
    logic       en;
    logic [3:0] shadow;
    logic       done;
    logic       busy;
    logic [7:0] issued;

    inc_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_ready (cmd_ready),
        .stall     (stall),
        .ld        (ld),
        .ui        (ui),
        .en        (en),
        .shadow    (shadow),
        .done      (done),
        .busy      (busy),
        .issued    (issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [3:0] arg;
        int         acc;
    } cmd_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    cmd_t mq[$];
    logic [3:0] m_shadow = 4'h0;
    int   m_issued = 0;
    bit   m_started = 0;
    bit   m_ld_seen = 0;
    int   m_en_seen = 0;

    logic       o_ld, o_en, o_done, o_acc;
    logic [3:0] o_ui;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_shadow  = 4'h0;
        m_issued  = 0;
        m_started = 0;
        m_ld_seen = 0;
        m_en_seen = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld"}, ld, 1'b0);
        check({tag, "_ui"}, ui, 4'h0);
        check({tag, "_en"}, en, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_shadow"}, shadow, 4'h0);
        check({tag, "_issued"}, issued, 8'h00);
    endtask

    // Per-cycle observation at the falling edge: state checks, then strobe accounting, then acceptance
    task automatic monitor();
        cmd_t c;
        check("shadow", shadow, m_shadow);
        check("issued", issued, m_issued);
        check("busy", busy, (mq.size() != 0));
        check("ld_en_excl", ld & en, 1'b0);
        if (!ld) check("ui_zero", ui, 4'h0);
        if (stall) check("stall_en", en, 1'b0);
        if (mq.size() < DEPTH) check("ready_room", cmd_ready, 1'b1);
        if (mq.size() > DEPTH) check("ready_full", cmd_ready, 1'b0);
        if (ld || en || done) begin
            if (mq.size() == 0) begin
                check("unexpected_strobe", {ld, en, done}, 3'b000);
            end else begin
                if (!m_started) begin
                    check("latency_min2", (cyc - mq[0].acc) >= 2, 1'b1);
                    m_started = 1;
                end
                if (ld) begin
                    check("ld_op", mq[0].op, 1'b0);
                    check("ld_ui", ui, mq[0].arg);
                    m_shadow  = mq[0].arg;
                    m_ld_seen = 1;
                end
                if (en) begin
                    check("en_op", mq[0].op, 1'b1);
                    check("en_overrun", m_en_seen < int'(mq[0].arg), 1'b1);
                    m_en_seen++;
                    m_shadow = m_shadow + 4'd1;
                end
                if (done) begin
                    if (mq[0].op == 1'b0) check("load_done_ld", m_ld_seen, 1'b1);
                    else check("inc_en_total", m_en_seen, int'(mq[0].arg));
                    void'(mq.pop_front());
                    if (m_issued < 255) m_issued++;
                    m_started = 0;
                    m_ld_seen = 0;
                    m_en_seen = 0;
                end
            end
        end
        if (cmd_valid && cmd_ready) begin
            c.op  = cmd_op;
            c.arg = cmd_arg;
            c.acc = cyc;
            mq.push_back(c);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        o_ld   = ld;
        o_en   = en;
        o_done = done;
        o_ui   = ui;
        o_acc  = cmd_valid && cmd_ready;
        @(posedge clk);
        #1;
        cyc++;
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic op, input logic [3:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        check("push_accept", o_acc, 1'b1);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        stall     = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int n;
        n = 0;
        stall     = 1'b0;
        cmd_valid = 1'b0;
        while ((mq.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check("drain_in_time", n < 300, 1'b1);
    endtask

    initial begin
        int en_cnt, done_cnt, first_en, last_en, fd, ac, n;
        bit exp_en[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // LOAD 9: ld two cycles after acceptance, for exactly one cycle
        do_reset();
        push(1'b0, 4'h9);
        tick();
        check("t033_ld_early", o_ld, 1'b0);
        tick();
        check("t033_ld", o_ld, 1'b1);
        check("t033_ui", o_ui, 4'h9);
        check("t033_done", o_done, 1'b1);
        tick();
        check("t033_ld_once", o_ld, 1'b0);
        check("t033_shadow", shadow, 4'h9);
        check("t033_issued", issued, 8'd1);

        // LOAD E then INC 3: three consecutive en, wrap through zero
        do_reset();
        push(1'b0, 4'hE);
        push(1'b1, 4'h3);
        en_cnt = 0; done_cnt = 0; first_en = -1; last_en = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_en) begin
                if (first_en < 0) first_en = i;
                last_en = i;
                en_cnt++;
            end
            if (o_done) done_cnt++;
        end
        check("t034_en_cnt", en_cnt, 3);
        check("t034_en_span", last_en - first_en, 2);
        check("t034_done_cnt", done_cnt, 2);
        check("t034_shadow", shadow, 4'h1);
        check("t034_issued", issued, 8'd2);

        // INC 4 with stall on the 2nd and 3rd INC cycles
        do_reset();
        push(1'b1, 4'h4);
        tick();
        check("t035_en_pop", o_en, 1'b0);
        for (int i = 0; i < 6; i++) begin
            stall = !exp_en[i];
            tick();
            check("t035_en_pat", o_en, exp_en[i]);
        end
        stall = 1'b0;
        tick();
        check("t035_done", o_done, 1'b1);
        check("t035_done_en", o_en, 1'b0);
        check("t035_shadow", shadow, 4'h4);

        // Fill the FIFO behind a stalled INC; the extra command waits for a pop
        do_reset();
        stall = 1'b1;
        push(1'b1, 4'h1);
        tick();
        tick();
        for (int i = 0; i <= DEPTH; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = i[0];
            cmd_arg   = 4'(i + 1);
            tick();
            check("t036_acc", o_acc, (i < DEPTH));
        end
        check("t036_ready_low", cmd_ready, 1'b0);
        stall = 1'b0;
        fd = -1; ac = -1;
        for (int i = 0; i < 20 && ac < 0; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 1'b1;
            cmd_arg   = 4'h2;
            tick();
            if (o_done && fd < 0) fd = cyc - 1;
            if (o_acc) ac = cyc - 1;
        end
        check("t036_accepted", ac >= 0, 1'b1);
        check("t036_acc_after_pop", ac - fd, 2);
        drain();

        // INC 0: no en, one done, shadow unchanged
        do_reset();
        push(1'b0, 4'h5);
        push(1'b1, 4'h0);
        en_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_en) en_cnt++;
            if (o_done) done_cnt++;
        end
        check("t037_en_cnt", en_cnt, 0);
        check("t037_done_cnt", done_cnt, 2);
        check("t037_shadow", shadow, 4'h5);
        check("t037_issued", issued, 8'd2);

        // Reset in the middle of INC 10 with two commands queued
        do_reset();
        push(1'b1, 4'hA);
        push(1'b0, 4'h3);
        push(1'b1, 4'h2);
        n = 0;
        while (!en && n < 20) begin
            tick();
            n++;
        end
        check("t038_en_started", en, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("t038_async");
        @(posedge clk);
        #1;
        check_reset_outputs("t038_held");
        rst = 1'b1;
        model_reset();
        en_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (o_en) en_cnt++;
            if (o_done) done_cnt++;
        end
        check("t038_no_en", en_cnt, 0);
        check("t038_no_done", done_cnt, 0);
        check("t038_idle", busy, 1'b0);

        // issued saturates at 255
        do_reset();
        for (int i = 0; i < 262; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 1'b0;
            cmd_arg   = 4'($urandom_range(0, 15));
            tick();
            while (!o_acc && mq.size() != 0) begin
                cmd_valid = 1'b1;
                tick();
            end
        end
        drain();
        check("sat_issued", issued, 8'd255);

        // Randomized traffic against the transaction model
        do_reset();
        for (int i = 0; i < 700; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 1'($urandom_range(0, 1));
            cmd_arg   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
            stall     = ($urandom_range(0, 4) == 0);
            tick();
        end
        drain();
        check("rand_queue_empty", mq.size(), 0);
        check("rand_shadow_final", shadow, m_shadow);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
